// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer: clamped parallel preset, pausable decrement, one-cycle done pulse.
// Optional auto-reload on terminal count when BCD_DOWN_RELOAD_EN is defined.
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                pause,
    output logic [4*DIGITS-1:0] count,
    output logic                busy,
    output logic                zero,
    output logic                done
);
    localparam int W = 4 * DIGITS;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           done_q, done_d;
`ifdef BCD_DOWN_RELOAD_EN
    logic [W-1:0]   reload_q, reload_d;
`endif

    function automatic logic [W-1:0] clamp9(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Borrow ripples up through zero digits; digits past the first non-zero one are untouched.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
`ifdef BCD_DOWN_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
`ifdef BCD_DOWN_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef BCD_DOWN_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            count_d  = clamp9(load_val);
            state_d  = IDLE;
`ifdef BCD_DOWN_RELOAD_EN
            reload_d = clamp9(load_val);
`endif
        end else if (state_q == IDLE) begin
            if (start && (count_q != '0)) state_d = RUN;
        end else if (!pause) begin
            if (count_q == '0) begin
`ifdef BCD_DOWN_RELOAD_EN
                count_d = reload_q;
`else
                state_d = IDLE;
`endif
            end else begin
                count_d = bcd_dec(count_q);
                if (count_q == W'(1)) begin
                    done_d = 1'b1;
`ifndef BCD_DOWN_RELOAD_EN
                    state_d = IDLE;
`endif
                end
            end
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign zero  = (count_q == '0);
    assign done  = done_q;

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Multi-digit BCD down-counter (countdown timer), the decrementing counterpart to the team's mod-10 up-counter. It takes a parallel BCD preset, counts down once per clock while running, and flags the terminal count with a one-cycle `done` pulse. It feeds timeout and display logic that needs decimal countdown values without binary-to-BCD conversion.

## Interface
- `DIGITS`, default 2: number of BCD digits; the count is `4*DIGITS` bits, with digit 0 in bits [3:0].
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: asynchronous reset, active-low.
- `load` input, 1: parallel-load strobe.
- `load_val` input, `4*DIGITS`: BCD preset.
- `start` input, 1: begin counting from the current value.
- `pause` input, 1: hold the count while running.
- `count` output, `4*DIGITS`: current BCD value.
- `busy` output, 1: high while in RUN.
- `zero` output, 1: combinational, `count == 0`.
- `done` output, 1: registered one-cycle terminal pulse.

## Operation
- Reset (`rst`=0, asynchronous): state IDLE, `count`=0, reload register=0, `busy`=0, `done`=0. `zero` is 1 during reset.
- States:
  - IDLE: count held.
  - RUN: count decrements once per cycle.
- Per-edge priority is `load` > `start` > decrement.
- `load` (any state):
  - `count` and the reload register take `load_val`, with each digit greater than 9 clamped to 9.
  - The state goes to IDLE and `done` goes to 0.
  - Loading mid-run aborts the run.
- `start` in IDLE:
  - If `count` is not 0, go to RUN.
  - If `count` is 0, ignore it (no RUN, no `done`).
  - `start` while already in RUN is ignored.
- Decrement (RUN, `pause`=0):
  - BCD subtract-1 with a borrow chain. A digit at 0 becomes 9 and borrows from the next digit; otherwise it decrements by 1.
  - Digits above the first non-zero digit are unchanged.
- `pause`=1 in RUN: `count` holds and the state stays RUN. `busy` stays 1.
- Terminal count: on the edge where `count` goes from 1 to 0, `done` is 1 for exactly the following cycle, in which `count` reads 0.
  - Without `BCD_DOWN_RELOAD_EN`: the state goes to IDLE on that same edge, so `busy`=0 while `count`=0.
  - With `BCD_DOWN_RELOAD_EN`: see Configuration.
- `done` is never high for two consecutive cycles. The only exception is a reload value of 0 under the macro, which is prohibited because `start` with `count`=0 is ignored.

## Timing
- `load` at edge k: `count` equals the clamped preset after edge k.
- `start` at edge k:
  - `busy`=1 after edge k.
  - The first decrement is at edge k+1.
  - A preset of N reaches 0 after edge k+N, and `done` is high during the cycle after edge k+N.
- A paused cycle adds exactly one cycle of latency per cycle of `pause`.
- `load` and `start` asserted together: the load wins and the state ends in IDLE. `start` must be re-asserted.
- `rst` asserted mid-run: outputs clear immediately, with no `done`.
- Full-scale preset with `DIGITS`=2: 99 takes 99 decrements to reach 0.

## Configuration
- `BCD_DOWN_RELOAD_EN` defined (auto-reload):
  - In RUN with `pause`=0 and `count`=0, the next edge loads the reload register into `count` and the state stays RUN.
  - The period is therefore reload+1 cycles, with `done` pulsing once per period in the cycle `count` reads 0.
  - A pause during the 0 cycle holds the 0; `done` is not re-asserted.
  - Only `load` or `rst` stops the run.
- Macro undefined: the block is a one-shot countdown. The reload register is omitted, except as needed to hold `load_val`, and RUN always exits to IDLE at 0.

## Test plan
- Reset then preset 25: `rst`=0 → `count`=00, `busy`=0, `zero`=1. Then load 0x25, start at edge k → `count` goes 25, 24, … 20, 19, … 01, 00. `count`=00 after edge k+25, `done` high for one cycle, `busy`=0, and `count` holds 00.
- Clamp and borrow: load 0xA3 → `count`=0x93. Start → after 4 edges 0x89 (the borrow across digits is correct). Load 0x0F → 0x09.
- Pause and ignored starts: start at 10, `pause` for 3 cycles when `count`=07 → `count` holds 07 for 3 cycles and `busy`=1. `done` comes 3 cycles later than without the pause. Start with `count`=00 → no RUN, no `done`.
- Aborts: load 0x40 while running at 0x17 → `count`=0x40, state IDLE, no `done`. `rst` pulsed low at `count`=05 → immediate 00, `busy`=0, `done`=0.
- Simultaneous `load`=1 and `start`=1 with `load_val`=0x12 → `count`=0x12, `busy`=0.
- `BCD_DOWN_RELOAD_EN`: load 03, start → `count` runs 03, 02, 01, 00, 03, 02, …, with `done` every 4th cycle and `busy` remaining 1. A `load` stops the run.
